// File: rtl/core_types_pkg.sv
// Shared tag types and default sizing for the rename map table and its lanes.
package core_types_pkg;

    localparam int DEFAULT_RENAME_WIDTH       = 2;
    localparam int DEFAULT_NUM_ARCH_REGS      = 32;
    localparam int DEFAULT_NUM_PHYS_REGS      = 64;
    localparam int DEFAULT_CHECKPOINT_COLUMNS = 4;
    localparam int DEFAULT_ROB_ENTRIES        = 64;

    typedef logic [$clog2(DEFAULT_NUM_ARCH_REGS)-1:0]      arch_reg_tag_t;
    typedef logic [$clog2(DEFAULT_NUM_PHYS_REGS)-1:0]      phys_reg_tag_t;
    typedef logic [$clog2(DEFAULT_ROB_ENTRIES)-1:0]        ROB_index_t;
    typedef logic [$clog2(DEFAULT_CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;

endpackage

// File: rtl/rename_bypass_lane.sv
// One dispatch lane's lookup: table value, overridden by the youngest earlier
// lane in the same group that renames the same architectural register.
module rename_bypass_lane #(
    parameter int LANE         = 0,
    parameter int RENAME_WIDTH = 2,
    parameter int ARCH_W       = 5,
    parameter int PHYS_W       = 6
) (
    input  logic [ARCH_W-1:0]                    src0_arch,
    input  logic [ARCH_W-1:0]                    src1_arch,
    input  logic [ARCH_W-1:0]                    old_dest_arch,
    input  logic [PHYS_W-1:0]                    src0_table,
    input  logic [PHYS_W-1:0]                    src1_table,
    input  logic [PHYS_W-1:0]                    old_dest_table,
    input  logic [RENAME_WIDTH-1:0]              rename_en,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]  rename_dest_arch,
    input  logic [RENAME_WIDTH-1:0][PHYS_W-1:0]  rename_dest_phys,
    output logic [PHYS_W-1:0]                    src0_phys,
    output logic [PHYS_W-1:0]                    src1_phys,
    output logic [PHYS_W-1:0]                    old_dest_phys
);

    // Ascending scan so the highest earlier lane overrides lower ones.
    always_comb begin
        src0_phys     = src0_table;
        src1_phys     = src1_table;
        old_dest_phys = old_dest_table;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (j < LANE && rename_en[j]) begin
                if (rename_dest_arch[j] == src0_arch)     src0_phys     = rename_dest_phys[j];
                if (rename_dest_arch[j] == src1_arch)     src1_phys     = rename_dest_phys[j];
                if (rename_dest_arch[j] == old_dest_arch) old_dest_phys = rename_dest_phys[j];
            end
        end
    end

endmodule

// File: rtl/phys_reg_map_table_mw.sv
// Multi-lane checkpointed architectural-to-physical register map table with
// revert, save, restore and invalidate of checkpoint columns.
module phys_reg_map_table_mw
    import core_types_pkg::*;
#(
    parameter int RENAME_WIDTH       = DEFAULT_RENAME_WIDTH,
    parameter int NUM_ARCH_REGS      = DEFAULT_NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS      = DEFAULT_NUM_PHYS_REGS,
    parameter int CHECKPOINT_COLUMNS = DEFAULT_CHECKPOINT_COLUMNS,
    parameter int ROB_ENTRIES        = DEFAULT_ROB_ENTRIES,
    localparam int ARCH_W = $clog2(NUM_ARCH_REGS),
    localparam int PHYS_W = $clog2(NUM_PHYS_REGS),
    localparam int ROB_W  = $clog2(ROB_ENTRIES),
    localparam int COL_W  = $clog2(CHECKPOINT_COLUMNS),
    localparam int CNT_W  = COL_W + 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    output logic                                 DUT_error,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]  src0_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]  src1_arch,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]  old_dest_arch,
    output logic [RENAME_WIDTH-1:0][PHYS_W-1:0]  src0_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_W-1:0]  src1_phys,
    output logic [RENAME_WIDTH-1:0][PHYS_W-1:0]  old_dest_phys,
    input  logic [RENAME_WIDTH-1:0]              rename_valid,
    input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0]  rename_dest_arch,
    input  logic [RENAME_WIDTH-1:0][PHYS_W-1:0]  rename_dest_phys,
    input  logic                                 revert_valid,
    input  logic [ARCH_W-1:0]                    revert_dest_arch,
    input  logic [PHYS_W-1:0]                    revert_safe_phys,
    input  logic [PHYS_W-1:0]                    revert_spec_phys,
    input  logic                                 save_valid,
    input  logic [ROB_W-1:0]                     save_ROB_index,
    output logic                                 save_ready,
    output logic [COL_W-1:0]                     save_safe_column,
    input  logic                                 restore_valid,
    input  logic                                 restore_failed,
    input  logic [ROB_W-1:0]                     restore_ROB_index,
    input  logic [COL_W-1:0]                     restore_column,
    output logic                                 restore_success,
    output logic [CNT_W-1:0]                     columns_used
);

    localparam logic [CNT_W-1:0]              COLS_CNT = CNT_W'(CHECKPOINT_COLUMNS);
    localparam logic [CHECKPOINT_COLUMNS-1:0] ONE_COL  = CHECKPOINT_COLUMNS'(1);

    logic [PHYS_W-1:0]             map_table [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
    logic [CHECKPOINT_COLUMNS-1:0] col_valid;
    logic [ROB_W-1:0]              col_tag [CHECKPOINT_COLUMNS];
    logic [COL_W-1:0]              working_col;
    logic [CNT_W-1:0]              used_count;
    logic                          error_q;

    logic [RENAME_WIDTH-1:0][PHYS_W-1:0] src0_tab, src1_tab, old_tab;
    logic [RENAME_WIDTH-1:0]             rename_en;
    logic                                restore_req, inval_req, save_req, rename_ok;
    logic                                do_save, tag_match, restore_ok, inval_ok, err_next;
    logic [COL_W-1:0]                    next_col;

    // Renames to arch 0 never take effect, so they neither write nor bypass.
    always_comb begin
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            src0_tab[l]  = map_table[working_col][src0_arch[l]];
            src1_tab[l]  = map_table[working_col][src1_arch[l]];
            old_tab[l]   = map_table[working_col][old_dest_arch[l]];
            rename_en[l] = rename_valid[l] && (rename_dest_arch[l] != '0);
        end
    end

    for (genvar g = 0; g < RENAME_WIDTH; g++) begin : g_lane
        rename_bypass_lane #(
            .LANE(g), .RENAME_WIDTH(RENAME_WIDTH), .ARCH_W(ARCH_W), .PHYS_W(PHYS_W)
        ) u_lane (
            .src0_arch(src0_arch[g]), .src1_arch(src1_arch[g]), .old_dest_arch(old_dest_arch[g]),
            .src0_table(src0_tab[g]), .src1_table(src1_tab[g]), .old_dest_table(old_tab[g]),
            .rename_en(rename_en), .rename_dest_arch(rename_dest_arch),
            .rename_dest_phys(rename_dest_phys),
            .src0_phys(src0_phys[g]), .src1_phys(src1_phys[g]), .old_dest_phys(old_dest_phys[g])
        );
    end

    // Exclusive priority revert > restore > save > rename; invalidate rides alongside.
    always_comb begin
        restore_req = restore_valid && restore_failed;
        inval_req   = restore_valid && !restore_failed;
        save_req    = save_valid && !revert_valid && !restore_req;
        rename_ok   = !revert_valid && !restore_req && !save_valid;
        save_ready  = used_count < COLS_CNT;
        do_save     = save_req && save_ready;
        next_col    = working_col + COL_W'(1);
        tag_match   = col_valid[restore_column] && (col_tag[restore_column] == restore_ROB_index);
        restore_ok  = restore_req && !revert_valid && tag_match;
        inval_ok    = inval_req && tag_match && (restore_column != working_col);
        restore_success = restore_ok || inval_ok;
        err_next = (save_valid && (revert_valid || restore_req))
                || (save_req && !save_ready)
                || ((|rename_valid) && !rename_ok)
                || (restore_req && revert_valid)
                || (revert_valid && (map_table[working_col][revert_dest_arch] != revert_spec_phys))
                || (inval_req && (restore_column == working_col));
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            if (rename_valid[l] && (rename_dest_arch[l] == '0)) err_next = 1'b1;
        end
    end

    // Later assignments in this block deliberately override earlier ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                for (int a = 0; a < NUM_ARCH_REGS; a++) begin
                    map_table[c][a] <= (c == 0) ? PHYS_W'(a) : '0;
                end
                col_tag[c] <= '0;
            end
            col_valid   <= ONE_COL;
            working_col <= '0;
            used_count  <= CNT_W'(1);
            error_q     <= 1'b0;
        end else begin
            error_q <= err_next;
            if (inval_ok) col_valid[restore_column] <= 1'b0;
            used_count <= used_count + CNT_W'(do_save) - CNT_W'(inval_ok);
            if (revert_valid) begin
                map_table[working_col][revert_dest_arch] <= revert_safe_phys;
            end else if (restore_req) begin
                if (restore_ok) begin
                    working_col <= restore_column;
                    col_valid   <= ONE_COL << restore_column;
                    used_count  <= CNT_W'(1);
                end
            end else if (save_req) begin
                if (do_save) begin
                    for (int a = 0; a < NUM_ARCH_REGS; a++) begin
                        map_table[next_col][a] <= map_table[working_col][a];
                    end
                    col_valid[next_col] <= 1'b1;
                    col_tag[working_col] <= save_ROB_index;
                    col_tag[next_col]    <= save_ROB_index;
                    working_col          <= next_col;
                end
            end else begin
                for (int l = 0; l < RENAME_WIDTH; l++) begin
                    if (rename_en[l]) map_table[working_col][rename_dest_arch[l]] <= rename_dest_phys[l];
                end
            end
        end
    end

    assign DUT_error        = error_q;
    assign save_safe_column = working_col;
    assign columns_used     = used_count;

endmodule

// File: tb/tb_phys_reg_map_table_mw.sv
// Scoreboard bench for phys_reg_map_table_mw: expectations are queued when
// stimulus is driven and popped when the corresponding output is sampled.
module tb_phys_reg_map_table_mw;

    logic            CLK = 1'b0;
    logic            RST;
    logic            DUT_error;
    logic [1:0][4:0] src0_arch, src1_arch, old_dest_arch;
    logic [1:0][5:0] src0_phys, src1_phys, old_dest_phys;
    logic [1:0]      rename_valid;
    logic [1:0][4:0] rename_dest_arch;
    logic [1:0][5:0] rename_dest_phys;
    logic            revert_valid;
    logic [4:0]      revert_dest_arch;
    logic [5:0]      revert_safe_phys, revert_spec_phys;
    logic            save_valid;
    logic [5:0]      save_ROB_index;
    logic            save_ready;
    logic [1:0]      save_safe_column;
    logic            restore_valid, restore_failed;
    logic [5:0]      restore_ROB_index;
    logic [1:0]      restore_column;
    logic            restore_success;
    logic [2:0]      columns_used;

    int checks = 0;
    int passed = 0;
    int exp;
    int exp_q[$];

    always #5 CLK = ~CLK;

    phys_reg_map_table_mw dut (
        .CLK(CLK), .RST(RST), .DUT_error(DUT_error),
        .src0_arch(src0_arch), .src1_arch(src1_arch), .old_dest_arch(old_dest_arch),
        .src0_phys(src0_phys), .src1_phys(src1_phys), .old_dest_phys(old_dest_phys),
        .rename_valid(rename_valid), .rename_dest_arch(rename_dest_arch),
        .rename_dest_phys(rename_dest_phys),
        .revert_valid(revert_valid), .revert_dest_arch(revert_dest_arch),
        .revert_safe_phys(revert_safe_phys), .revert_spec_phys(revert_spec_phys),
        .save_valid(save_valid), .save_ROB_index(save_ROB_index),
        .save_ready(save_ready), .save_safe_column(save_safe_column),
        .restore_valid(restore_valid), .restore_failed(restore_failed),
        .restore_ROB_index(restore_ROB_index), .restore_column(restore_column),
        .restore_success(restore_success), .columns_used(columns_used)
    );

    task automatic clear_inputs();
        src0_arch = '0; src1_arch = '0; old_dest_arch = '0;
        rename_valid = '0; rename_dest_arch = '0; rename_dest_phys = '0;
        revert_valid = 1'b0; revert_dest_arch = '0; revert_safe_phys = '0; revert_spec_phys = '0;
        save_valid = 1'b0; save_ROB_index = '0;
        restore_valid = 1'b0; restore_failed = 1'b0; restore_ROB_index = '0; restore_column = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        save_valid = 1'b1; save_ROB_index = 6'd9;
        rename_valid = 2'b01; rename_dest_arch[0] = 5'd7; rename_dest_phys[0] = 6'd60;
        step();
        step();
        RST = 1'b0;
        clear_inputs();
        src0_arch[0] = 5'd5; src1_arch[1] = 5'd31; old_dest_arch[0] = 5'd7;
        #1;
        exp_q.push_back(5); exp_q.push_back(31); exp_q.push_back(7);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL reset_src0: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src1_phys[1] !== exp) $display("[TB] FAIL reset_src1: got %0d expected %0d", src1_phys[1], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (old_dest_phys[0] !== exp) $display("[TB] FAIL reset_discard_rename: got %0d expected %0d", old_dest_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL reset_used: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_ready !== exp) $display("[TB] FAIL reset_ready: got %0d expected %0d", save_ready, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL reset_col: got %0d expected %0d", save_safe_column, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL reset_err: got %0d expected %0d", DUT_error, exp); else passed++;
    endtask

    task automatic test_bypass();
        clear_inputs();
        rename_valid = 2'b11;
        rename_dest_arch[0] = 5'd3; rename_dest_phys[0] = 6'd40;
        rename_dest_arch[1] = 5'd3; rename_dest_phys[1] = 6'd41;
        src0_arch[1] = 5'd3; old_dest_arch[1] = 5'd3; old_dest_arch[0] = 5'd3;
        #1;
        exp_q.push_back(40); exp_q.push_back(40); exp_q.push_back(3);
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[1] !== exp) $display("[TB] FAIL bypass_src0: got %0d expected %0d", src0_phys[1], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (old_dest_phys[1] !== exp) $display("[TB] FAIL bypass_old: got %0d expected %0d", old_dest_phys[1], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (old_dest_phys[0] !== exp) $display("[TB] FAIL lane0_old: got %0d expected %0d", old_dest_phys[0], exp); else passed++;
        step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(41); exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL waw_winner: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL bypass_err: got %0d expected %0d", DUT_error, exp); else passed++;
    endtask

    task automatic test_arch0();
        clear_inputs();
        rename_valid = 2'b01; rename_dest_arch[0] = 5'd0; rename_dest_phys[0] = 6'd63;
        step();
        clear_inputs();
        #1;
        exp_q.push_back(1); exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL arch0_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL arch0_unchanged: got %0d expected %0d", src0_phys[0], exp); else passed++;
        step();
        exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL err_one_cycle: got %0d expected %0d", DUT_error, exp); else passed++;
    endtask

    task automatic test_revert();
        clear_inputs();
        rename_valid = 2'b01; rename_dest_arch[0] = 5'd3; rename_dest_phys[0] = 6'd51;
        step();
        clear_inputs();
        revert_valid = 1'b1; revert_dest_arch = 5'd3; revert_safe_phys = 6'd20; revert_spec_phys = 6'd50;
        step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(1); exp_q.push_back(20);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL revert_spec_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL revert_write: got %0d expected %0d", src0_phys[0], exp); else passed++;
        clear_inputs();
        revert_valid = 1'b1; revert_dest_arch = 5'd3; revert_safe_phys = 6'd22; revert_spec_phys = 6'd20;
        step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(0); exp_q.push_back(22);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL revert_ok_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL revert_ok_write: got %0d expected %0d", src0_phys[0], exp); else passed++;
        clear_inputs();
        revert_valid = 1'b1; revert_dest_arch = 5'd4; revert_safe_phys = 6'd33; revert_spec_phys = 6'd4;
        rename_valid = 2'b10; rename_dest_arch[1] = 5'd5; rename_dest_phys[1] = 6'd44;
        step();
        clear_inputs();
        src0_arch[0] = 5'd4; src1_arch[0] = 5'd5;
        #1;
        exp_q.push_back(1); exp_q.push_back(33); exp_q.push_back(5);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL drop_rename_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL revert_win: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src1_phys[0] !== exp) $display("[TB] FAIL rename_dropped: got %0d expected %0d", src1_phys[0], exp); else passed++;
    endtask

    task automatic test_save_full();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            clear_inputs();
            save_valid = 1'b1; save_ROB_index = 6'(k);
            step();
            clear_inputs();
            #1;
            exp_q.push_back(k + 1); exp_q.push_back(k);
            exp = exp_q.pop_front(); checks++;
            if (columns_used !== exp) $display("[TB] FAIL save_used_%0d: got %0d expected %0d", k, columns_used, exp); else passed++;
            exp = exp_q.pop_front(); checks++;
            if (save_safe_column !== exp) $display("[TB] FAIL save_col_%0d: got %0d expected %0d", k, save_safe_column, exp); else passed++;
        end
        save_valid = 1'b1; save_ROB_index = 6'd4;
        #1;
        exp_q.push_back(0); exp_q.push_back(4);
        exp = exp_q.pop_front(); checks++;
        if (save_ready !== exp) $display("[TB] FAIL full_ready: got %0d expected %0d", save_ready, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL full_used: got %0d expected %0d", columns_used, exp); else passed++;
        step();
        clear_inputs();
        #1;
        exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(3);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL full_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL full_used_after: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL full_col_after: got %0d expected %0d", save_safe_column, exp); else passed++;
    endtask

    task automatic test_restore();
        do_reset();
        clear_inputs(); rename_valid = 2'b01; rename_dest_arch[0] = 5'd3; rename_dest_phys[0] = 6'd45; step();
        clear_inputs(); save_valid = 1'b1; save_ROB_index = 6'd7; step();
        clear_inputs(); rename_valid = 2'b01; rename_dest_arch[0] = 5'd3; rename_dest_phys[0] = 6'd46; step();
        clear_inputs(); save_valid = 1'b1; save_ROB_index = 6'd9; step();
        clear_inputs(); rename_valid = 2'b01; rename_dest_arch[0] = 5'd3; rename_dest_phys[0] = 6'd50; step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(50); exp_q.push_back(3); exp_q.push_back(2);
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL setup_r3: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL setup_used: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL setup_col: got %0d expected %0d", save_safe_column, exp); else passed++;

        restore_valid = 1'b1; restore_failed = 1'b1; restore_column = 2'd0; restore_ROB_index = 6'd5;
        #1;
        exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (restore_success !== exp) $display("[TB] FAIL bad_tag_success: got %0d expected %0d", restore_success, exp); else passed++;
        step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(50); exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL bad_tag_col: got %0d expected %0d", save_safe_column, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL bad_tag_used: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL bad_tag_r3: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL bad_tag_err: got %0d expected %0d", DUT_error, exp); else passed++;

        restore_valid = 1'b1; restore_failed = 1'b0; restore_column = 2'd2; restore_ROB_index = 6'd9;
        #1;
        exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (restore_success !== exp) $display("[TB] FAIL inval_work_success: got %0d expected %0d", restore_success, exp); else passed++;
        step();
        clear_inputs();
        #1;
        exp_q.push_back(1); exp_q.push_back(3);
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL inval_work_err: got %0d expected %0d", DUT_error, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL inval_work_used: got %0d expected %0d", columns_used, exp); else passed++;

        restore_valid = 1'b1; restore_failed = 1'b0; restore_column = 2'd0; restore_ROB_index = 6'd7;
        save_valid = 1'b1; save_ROB_index = 6'd11;
        #1;
        exp_q.push_back(1);
        exp = exp_q.pop_front(); checks++;
        if (restore_success !== exp) $display("[TB] FAIL inval_save_success: got %0d expected %0d", restore_success, exp); else passed++;
        step();
        clear_inputs();
        #1;
        exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(0);
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL inval_save_used: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL inval_save_col: got %0d expected %0d", save_safe_column, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (DUT_error !== exp) $display("[TB] FAIL inval_save_err: got %0d expected %0d", DUT_error, exp); else passed++;

        restore_valid = 1'b1; restore_failed = 1'b1; restore_column = 2'd1; restore_ROB_index = 6'd9;
        #1;
        exp_q.push_back(1);
        exp = exp_q.pop_front(); checks++;
        if (restore_success !== exp) $display("[TB] FAIL restore_success: got %0d expected %0d", restore_success, exp); else passed++;
        step();
        clear_inputs();
        src0_arch[0] = 5'd3;
        #1;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(46); exp_q.push_back(1);
        exp = exp_q.pop_front(); checks++;
        if (save_safe_column !== exp) $display("[TB] FAIL restore_col: got %0d expected %0d", save_safe_column, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (columns_used !== exp) $display("[TB] FAIL restore_used: got %0d expected %0d", columns_used, exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (src0_phys[0] !== exp) $display("[TB] FAIL restore_r3: got %0d expected %0d", src0_phys[0], exp); else passed++;
        exp = exp_q.pop_front(); checks++;
        if (save_ready !== exp) $display("[TB] FAIL restore_ready: got %0d expected %0d", save_ready, exp); else passed++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_arch0();
        test_revert();
        test_save_full();
        test_restore();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
